// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern sequencer and its PRPG.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        EVAL    = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

    // Bits needed to hold 0..max_value without wrapping.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois PRPG feeding scan-in data; serial output is state[0].
// Latency: load/advance take effect on the next rising edge.
// Backpressure: none; the sequencer decides when the generator steps.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_LFSR_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_LFSR_TAPS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    // An all-zero Galois register never leaves zero, so reject it at elaboration.
    if (SEED == '0) begin : g_bad_seed
        $error("bist_lfsr: SEED must be nonzero");
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (advance) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST-per-scan sequencer: loads PRPG patterns, strobes capture, frames the MISR window, latches the verdict.
// Latency: 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles from the start-sampling edge to done.
// Backpressure: none; start is only accepted in IDLE or DONE and ignored while busy.
module bist_pattern_ctrl
    import bist_pkg::*;
#(
    parameter int                    CHAIN_LEN    = 32,
    parameter int                    NUM_PATTERNS = 256,
    parameter int                    LFSR_WIDTH   = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = LFSR_WIDTH'(DEF_LFSR_SEED),
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = LFSR_WIDTH'(DEF_LFSR_TAPS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                pass_nfail,
    output logic                                scan_in,
    output logic                                scan_en,
    output logic                                capture,
    output logic                                misr_reset,
    output logic                                misr_en,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_count
);

    localparam int PCW = $clog2(NUM_PATTERNS + 1);
    localparam int SCW = count_width(CHAIN_LEN - 1);

    if (CHAIN_LEN < 2) begin : g_bad_chain
        $error("bist_pattern_ctrl: CHAIN_LEN must be >= 2");
    end
    if (NUM_PATTERNS < 1) begin : g_bad_patterns
        $error("bist_pattern_ctrl: NUM_PATTERNS must be >= 1");
    end

    state_t                  state;
    state_t                  next_state;
    logic [SCW-1:0]          shift_cnt;
    logic                    shift_last;
    logic                    last_pattern;
    logic [LFSR_WIDTH-1:0]   lfsr_state;
    logic                    lfsr_load;
    logic                    lfsr_advance;
    logic                    scan_in_d;
    logic                    scan_en_d;
    logic                    capture_d;
    logic                    misr_reset_d;
    logic                    misr_en_d;
    logic                    busy_d;
    logic                    unused_lfsr_hi;

    bist_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .state   (lfsr_state)
    );

    // Only the serial bit reaches the chain; the rest is kept for debug visibility.
    assign unused_lfsr_hi = ^lfsr_state[LFSR_WIDTH-1:1];

    assign shift_last   = (shift_cnt == SCW'(CHAIN_LEN - 1));
    assign last_pattern = (pattern_count == PCW'(NUM_PATTERNS));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from next_state so the registered copies line up with the state they describe.
    always_comb begin
        next_state   = state;
        scan_in_d    = 1'b0;
        scan_en_d    = 1'b0;
        capture_d    = 1'b0;
        misr_reset_d = 1'b0;
        misr_en_d    = 1'b0;
        busy_d       = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;

        case (state)
            IDLE, DONE: if (start) next_state = INIT;
            INIT:       next_state = SHIFT;
            SHIFT:      if (shift_last) next_state = CAPTURE;
            CAPTURE:    next_state = last_pattern ? UNLOAD : SHIFT;
            UNLOAD:     if (shift_last) next_state = EVAL;
            EVAL:       next_state = DONE;
            default:    next_state = IDLE;
        endcase

        case (next_state)
            INIT: begin
                misr_reset_d = 1'b1;
                busy_d       = 1'b1;
                lfsr_load    = 1'b1;
            end
            SHIFT: begin
                scan_in_d    = lfsr_state[0];
                scan_en_d    = 1'b1;
                misr_en_d    = 1'b1;
                busy_d       = 1'b1;
                lfsr_advance = 1'b1;
            end
            CAPTURE: begin
                capture_d = 1'b1;
                busy_d    = 1'b1;
            end
            UNLOAD: begin
                scan_en_d = 1'b1;
                misr_en_d = 1'b1;
                busy_d    = 1'b1;
            end
            EVAL:    busy_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_in       <= 1'b0;
            scan_en       <= 1'b0;
            capture       <= 1'b0;
            misr_reset    <= 1'b0;
            misr_en       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            pattern_count <= '0;
            shift_cnt     <= '0;
        end else begin
            scan_in    <= scan_in_d;
            scan_en    <= scan_en_d;
            capture    <= capture_d;
            misr_reset <= misr_reset_d;
            misr_en    <= misr_en_d;
            busy       <= busy_d;

            if ((state == SHIFT) || (state == UNLOAD)) begin
                shift_cnt <= shift_last ? '0 : shift_cnt + SCW'(1);
            end else begin
                shift_cnt <= '0;
            end

            if (next_state == INIT) begin
                pattern_count <= '0;
            end else if (next_state == CAPTURE) begin
                pattern_count <= pattern_count + PCW'(1);
            end

            // Verdict is sticky until the next accepted start.
            if (next_state == INIT) begin
                done <= 1'b0;
                pass <= 1'b0;
            end else if (state == EVAL) begin
                done <= 1'b1;
                pass <= pass_nfail;
            end
        end
    end

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed scoreboard bench for bist_pattern_ctrl with CHAIN_LEN=4, NUM_PATTERNS=3.
module tb_bist_pattern_ctrl;

    localparam int   CL = 4;
    localparam int   NP = 3;
    localparam logic Z  = 1'b0;
    localparam logic H  = 1'b1;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        pass_nfail;
    logic        scan_in;
    logic        scan_en;
    logic        capture;
    logic        misr_reset;
    logic        misr_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  pattern_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    bist_pattern_ctrl #(
        .CHAIN_LEN    (CL),
        .NUM_PATTERNS (NP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .pass_nfail    (pass_nfail),
        .scan_in       (scan_in),
        .scan_en       (scan_en),
        .capture       (capture),
        .misr_reset    (misr_reset),
        .misr_en       (misr_en),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .pattern_count (pattern_count)
    );

    function automatic logic [31:0] mk(input logic si, input logic en, input logic cap,
                                       input logic mr, input logic me, input logic bz,
                                       input logic dn, input logic ps, input logic [1:0] cnt);
        return {22'd0, si, en, cap, mr, me, bz, dn, ps, cnt};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {22'd0, scan_in, scan_en, capture, misr_reset, misr_en, busy, done, pass, pattern_count};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected per-cycle outputs of one full run, starting with the INIT cycle.
    task automatic push_run(input logic pnf, input int hold);
        logic [15:0] l;
        logic [15:0] taps;
        l    = 16'hACE1;
        taps = 16'hB400;
        exp_q.push_back(mk(Z, Z, Z, H, Z, H, Z, Z, 2'd0));
        for (int p = 1; p <= NP; p++) begin
            for (int b = 0; b < CL; b++) begin
                exp_q.push_back(mk(l[0], H, Z, Z, H, H, Z, Z, 2'(p - 1)));
                l = (l >> 1) ^ (l[0] ? taps : 16'h0000);
            end
            exp_q.push_back(mk(Z, Z, H, Z, Z, H, Z, Z, 2'(p)));
        end
        for (int b = 0; b < CL; b++) begin
            exp_q.push_back(mk(Z, H, Z, Z, H, H, Z, Z, 2'(NP)));
        end
        exp_q.push_back(mk(Z, Z, Z, Z, Z, H, Z, Z, 2'(NP)));
        for (int h = 0; h <= hold; h++) begin
            exp_q.push_back(mk(Z, Z, Z, Z, Z, Z, H, pnf, 2'(NP)));
        end
    endtask

    task automatic run(input logic pnf, input int hold, input bit pulses, input int abort_at);
        int          k;
        int          n_me;
        int          n_cap;
        logic [31:0] expv;
        k     = 0;
        n_me  = 0;
        n_cap = 0;
        push_run(pnf, hold);
        start      = 1'b1;
        pass_nfail = ~pnf;
        @(posedge clock); #1;
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            check($sformatf("run_k%0d", k), obs_vec(), expv);
            n_me  += int'(misr_en);
            n_cap += int'(capture);
            if (k == abort_at) begin
                exp_q.delete();
                start = 1'b0;
                reset = 1'b0;
                #1;
                check("abort_async_clear", obs_vec(), 32'd0);
                repeat (2) @(posedge clock);
                #1;
                reset = 1'b1;
                repeat (2) @(posedge clock);
                #1;
                check("abort_then_idle", obs_vec(), 32'd0);
            end else begin
                start      = pulses && ((k == 2) || (k == 5));
                pass_nfail = (k == 20) ? pnf : ~pnf;
                if (exp_q.size() > 0) begin
                    @(posedge clock); #1;
                end
                k++;
            end
        end
        if (abort_at < 0) begin
            check("misr_en_cycles", n_me, 16);
            check("capture_strobes", n_cap, 3);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        pass_nfail = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", obs_vec(), 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle_without_start", obs_vec(), 32'd0);

        run(1'b1, 50, 1'b0, -1);
        run(1'b0, 3, 1'b1, -1);
        run(1'b1, 0, 1'b0, 7);
        run(1'b0, 2, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
